// File: rtl/uart_alu_sequencer_if.sv
// Bus between the frame sequencer and its UART RX, ALU and UART TX neighbours.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface uart_alu_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 6
);
    logic              i_rx_done;
    logic [DATA_W-1:0] i_rx_data;
    logic [DATA_W-1:0] i_alu_result;
    logic              i_tx_done;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic [OP_W-1:0]   o_alu_op;
    logic              o_tx_start;
    logic [DATA_W-1:0] o_tx_data;
    logic              o_busy;
    logic              o_timeout;
    logic              o_overrun;

    modport slave (
        input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
        output o_busy, o_timeout, o_overrun
    );

    modport master (
        output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
        input  o_busy, o_timeout, o_overrun
    );
endinterface

// File: rtl/uart_alu_sequencer.sv
// Collects operand A, operand B and opcode from UART RX, drives the ALU, and
// hands the result to UART TX; a watchdog aborts frames that stall between bytes.
module uart_alu_sequencer #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned OP_W           = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    uart_alu_sequencer_if.slave      bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_COMPUTE,
        S_SEND,
        S_WAIT_TX
    } state_e;

    state_e            state_q,    state_d;
    logic [DATA_W-1:0] alu_a_q,    alu_a_d;
    logic [DATA_W-1:0] alu_b_q,    alu_b_d;
    logic [OP_W-1:0]   alu_op_q,   alu_op_d;
    logic [DATA_W-1:0] tx_data_q,  tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              timeout_q,  timeout_d;
    logic              overrun_q,  overrun_d;
    logic [CNT_W-1:0]  wd_cnt_q,   wd_cnt_d;
    logic              wd_expired;

    // Watchdog only runs while waiting for the 2nd/3rd byte; an arriving byte beats expiry.
    assign wd_expired = (wd_cnt_q == WD_LAST) && !bus.i_rx_done;

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        overrun_d  = 1'b0;
        wd_cnt_d   = '0;

        case (state_q)
            S_WAIT_A: begin
                if (bus.i_rx_done) begin
                    alu_a_d = bus.i_rx_data;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B, S_WAIT_OP: begin
                if (bus.i_rx_done) begin
                    if (state_q == S_WAIT_B) begin
                        alu_b_d = bus.i_rx_data;
                        state_d = S_WAIT_OP;
                    end else begin
                        alu_op_d = bus.i_rx_data[OP_W-1:0];
                        state_d  = S_COMPUTE;
                    end
                end else if (wd_expired) begin
                    alu_a_d   = '0;
                    alu_b_d   = '0;
                    alu_op_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = S_WAIT_A;
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
            end
            S_COMPUTE: begin
                tx_data_d  = bus.i_alu_result;
                tx_start_d = 1'b1;
                overrun_d  = bus.i_rx_done;
                state_d    = S_SEND;
            end
            S_SEND: begin
                overrun_d = bus.i_rx_done;
                state_d   = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                overrun_d = bus.i_rx_done;
                if (bus.i_tx_done) begin
                    state_d = S_WAIT_A;
                end
            end
            default: state_d = S_WAIT_A;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= S_WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    assign bus.o_alu_a    = alu_a_q;
    assign bus.o_alu_b    = alu_b_q;
    assign bus.o_alu_op   = alu_op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_timeout  = timeout_q;
    assign bus.o_overrun  = overrun_q;
    assign bus.o_busy     = (state_q != S_WAIT_A);
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer with a small opcode-decoding ALU model
// (0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR) and a watchdog of 50 cycles.
module tb_uart_alu_sequencer;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned TIMEOUT = 50;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;
    int   start_cnt;

    uart_alu_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    uart_alu_sequencer #(
        .DATA_W         (DATA_W),
        .OP_W           (OP_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb bus.i_alu_result = alu_model(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

    always @(negedge clk) if (bus.o_tx_start === 1'b1) start_cnt++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = b;
        tick();
        bus.i_rx_done = 1'b0;
    endtask

    task automatic tx_done_pulse();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
    endtask

    // Full frame: three bytes, result capture, single start pulse, TX completion.
    task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] exp);
        int s0;
        s0 = start_cnt;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        chk({tag, "_op"}, 32'(bus.o_alu_op), 32'(op[5:0]));
        chk({tag, "_start_early"}, 32'(bus.o_tx_start), 32'd0);
        tick();
        chk({tag, "_tx_data"}, 32'(bus.o_tx_data), 32'(exp));
        chk({tag, "_start"}, 32'(bus.o_tx_start), 32'd1);
        tick();
        chk({tag, "_start_off"}, 32'(bus.o_tx_start), 32'd0);
        chk({tag, "_busy_tx"}, 32'(bus.o_busy), 32'd1);
        repeat (3) tick();
        chk({tag, "_one_start"}, 32'(start_cnt - s0), 32'd1);
        tx_done_pulse();
        chk({tag, "_idle"}, 32'(bus.o_busy), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        start_cnt = 0;
        rst_n = 1'b0;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = '0;
        bus.i_tx_done = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // 1: reset asserted while waiting for the opcode
        send_byte(8'h11);
        send_byte(8'h22);
        chk("t1_busy_pre", 32'(bus.o_busy), 32'd1);
        rst_n = 1'b0;
        repeat (3) tick();
        chk("t1_alu_a", 32'(bus.o_alu_a), 32'd0);
        chk("t1_alu_b", 32'(bus.o_alu_b), 32'd0);
        chk("t1_alu_op", 32'(bus.o_alu_op), 32'd0);
        chk("t1_tx_data", 32'(bus.o_tx_data), 32'd0);
        chk("t1_flags", {29'd0, bus.o_tx_start, bus.o_timeout, bus.o_overrun}, 32'd0);
        chk("t1_busy", 32'(bus.o_busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // 2: ADD 5 + 3
        frame("t2", 8'h05, 8'h03, 8'h20, 8'h08);
        chk("t2_a", 32'(bus.o_alu_a), 32'h05);

        // 3: watchdog abort after 50 silent cycles, then SUB frame
        send_byte(8'h05);
        send_byte(8'h03);
        repeat (TIMEOUT - 1) tick();
        chk("t3_no_to_yet", 32'(bus.o_timeout), 32'd0);
        chk("t3_busy_yet", 32'(bus.o_busy), 32'd1);
        tick();
        chk("t3_timeout", 32'(bus.o_timeout), 32'd1);
        chk("t3_busy", 32'(bus.o_busy), 32'd0);
        chk("t3_ops_clr", {8'd0, bus.o_alu_a, bus.o_alu_b, 2'd0, bus.o_alu_op}, 32'd0);
        tick();
        chk("t3_to_pulse", 32'(bus.o_timeout), 32'd0);
        frame("t3f", 8'h0F, 8'h01, 8'h22, 8'h0E);

        // 4: byte on the expiry cycle is accepted; counter restarts in WAIT_OP
        send_byte(8'h01);
        repeat (TIMEOUT - 1) tick();
        send_byte(8'h02);
        chk("t4_no_to", 32'(bus.o_timeout), 32'd0);
        chk("t4_busy", 32'(bus.o_busy), 32'd1);
        chk("t4_alu_b", 32'(bus.o_alu_b), 32'h02);
        repeat (TIMEOUT - 1) tick();
        send_byte(8'h20);
        chk("t4_op", 32'(bus.o_alu_op), 32'h20);
        tick();
        chk("t4_tx_data", 32'(bus.o_tx_data), 32'h03);
        chk("t4_start", 32'(bus.o_tx_start), 32'd1);
        tick();
        tx_done_pulse();
        chk("t4_idle", 32'(bus.o_busy), 32'd0);

        // 5: late RX byte during WAIT_TX, then RX and TX done together
        send_byte(8'h07);
        send_byte(8'h02);
        send_byte(8'h22);
        tick();
        tick();
        send_byte(8'hAA);
        chk("t5_overrun", 32'(bus.o_overrun), 32'd1);
        chk("t5_tx_data", 32'(bus.o_tx_data), 32'h05);
        chk("t5_no_start", 32'(bus.o_tx_start), 32'd0);
        chk("t5_busy", 32'(bus.o_busy), 32'd1);
        tick();
        chk("t5_ovr_pulse", 32'(bus.o_overrun), 32'd0);
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = 8'h55;
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        chk("t5_both_ovr", 32'(bus.o_overrun), 32'd1);
        chk("t5_both_idle", 32'(bus.o_busy), 32'd0);
        chk("t5_a_kept", 32'(bus.o_alu_a), 32'h07);
        tx_done_pulse();
        chk("t5_txd_ignored", 32'(bus.o_busy), 32'd0);

        // 6: back-to-back frames
        frame("t6a", 8'hFF, 8'h01, 8'h20, 8'h00);
        frame("t6b", 8'h80, 8'h80, 8'h24, 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
